// File: rtl/pc_pkg.sv
// +----------------------------------------------------------------------------+
// | pc_pkg : branch-condition encodings shared by the program-counter unit      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

  typedef enum logic [1:0] {
    BR_BEQ = 2'd0,
    BR_BNE = 2'd1,
    BR_BLT = 2'd2,
    BR_BGE = 2'd3
  } br_mode_t;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// +----------------------------------------------------------------------------+
// | ras_stack : circular return-address stack with sticky overflow/underflow    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ras_stack #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         hold,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         ovf,
  output logic                         udf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  logic [PTR_W-1:0] w_sp_dec;
  logic             w_empty;
  logic             w_full;

  // r_sp is the next free slot; the top entry sits just below it
  assign w_sp_dec = r_sp - PTR_W'(1);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(RAS_DEPTH));

  assign top   = r_mem[w_sp_dec];
  assign count = r_count;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

  always_ff @(posedge CLK) begin
    if (!RESET && !hold && push) begin
      if (pop && !w_empty)
        r_mem[w_sp_dec] <= push_data;
      else
        r_mem[r_sp] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (!hold) begin
      if (push && pop) begin
        // replacing the top leaves count alone; on empty it degrades to a push
        if (w_empty) begin
          r_sp    <= r_sp + PTR_W'(1);
          r_count <= CNT_W'(1);
          r_udf   <= 1'b1;
        end
      end else if (push) begin
        r_sp <= r_sp + PTR_W'(1);
        if (w_full)
          r_ovf <= 1'b1;
        else
          r_count <= r_count + CNT_W'(1);
      end else if (pop) begin
        if (w_empty) begin
          r_udf <= 1'b1;
        end else begin
          r_sp    <= w_sp_dec;
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit_ras.sv
// +----------------------------------------------------------------------------+
// | pc_unit_ras : program counter with branch/jump/call/ret and return stack    |
// | Optional PC_PERF_CNT_EN adds TAKEN_CNT / STALL_CNT counters.   Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter int              OFFSET_W     = 8,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        BUSYWAIT,
  input  logic                        BRANCH,
  input  logic [1:0]                  BR_MODE,
  input  logic                        ZERO,
  input  logic                        SIGN,
  input  logic                        JUMP,
  input  logic                        CALL,
  input  logic                        RET,
  input  logic [OFFSET_W-1:0]         OFFSET,
  output logic [PC_W-1:0]             PC,
  output logic [PC_W-1:0]             PC_PLUS4,
  output logic [$clog2(RAS_DEPTH):0]  RAS_COUNT,
  output logic                        RAS_OVF,
  output logic                        RAS_UDF
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]                 TAKEN_CNT,
  output logic [31:0]                 STALL_CNT
`endif
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_offset_ext;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_ras_top;
  logic [PC_W-1:0] w_next_pc;
  logic            w_cond;
  logic            w_taken;
  br_mode_t        w_mode;

  assign w_mode       = br_mode_t'(BR_MODE);
  assign w_pc_plus4   = r_pc + PC_W'(4);
  assign w_offset_ext = {{(PC_W-OFFSET_W){OFFSET[OFFSET_W-1]}}, OFFSET};
  assign w_target     = w_pc_plus4 + (w_offset_ext << 2);

  always_comb begin
    w_cond = 1'b0;
    case (w_mode)
      BR_BEQ:  w_cond = ZERO;
      BR_BNE:  w_cond = ~ZERO;
      BR_BLT:  w_cond = SIGN;
      BR_BGE:  w_cond = ~SIGN;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = BRANCH & w_cond;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (RET)
      w_next_pc = (RAS_COUNT == '0) ? RESET_VECTOR : w_ras_top;
    else if (JUMP || CALL)
      w_next_pc = w_target;
    else if (w_taken)
      w_next_pc = w_target;
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r_pc <= RESET_VECTOR;
    else if (!BUSYWAIT)
      r_pc <= w_next_pc;
  end

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RESET     (RESET),
    .hold      (BUSYWAIT),
    .push      (CALL),
    .pop       (RET),
    .push_data (w_pc_plus4),
    .top       (w_ras_top),
    .count     (RAS_COUNT),
    .ovf       (RAS_OVF),
    .udf       (RAS_UDF)
  );

  assign PC       = r_pc;
  assign PC_PLUS4 = w_pc_plus4;

`ifdef PC_PERF_CNT_EN
  logic [31:0] r_taken_cnt;
  logic [31:0] r_stall_cnt;

  // a stalled control-flow change is only counted on the edge it retires
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (BUSYWAIT) begin
        if (r_stall_cnt != '1)
          r_stall_cnt <= r_stall_cnt + 32'd1;
      end else if (RET || JUMP || CALL || w_taken) begin
        if (r_taken_cnt != '1)
          r_taken_cnt <= r_taken_cnt + 32'd1;
      end
    end
  end

  assign TAKEN_CNT = r_taken_cnt;
  assign STALL_CNT = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_unit_ras.sv
// +----------------------------------------------------------------------------+
// | tb_pc_unit_ras : directed self-checking bench for pc_unit_ras (defaults)    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_unit_ras;

  logic        CLK = 1'b0;
  logic        RESET, BUSYWAIT, BRANCH, ZERO, SIGN, JUMP, CALL, RET;
  logic [1:0]  BR_MODE;
  logic [7:0]  OFFSET;
  logic [31:0] PC, PC_PLUS4;
  logic [2:0]  RAS_COUNT;
  logic        RAS_OVF, RAS_UDF;
`ifdef PC_PERF_CNT_EN
  logic [31:0] TAKEN_CNT, STALL_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  pc_unit_ras dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUSYWAIT  (BUSYWAIT),
    .BRANCH    (BRANCH),
    .BR_MODE   (BR_MODE),
    .ZERO      (ZERO),
    .SIGN      (SIGN),
    .JUMP      (JUMP),
    .CALL      (CALL),
    .RET       (RET),
    .OFFSET    (OFFSET),
    .PC        (PC),
    .PC_PLUS4  (PC_PLUS4),
    .RAS_COUNT (RAS_COUNT),
    .RAS_OVF   (RAS_OVF),
    .RAS_UDF   (RAS_UDF)
`ifdef PC_PERF_CNT_EN
    ,
    .TAKEN_CNT (TAKEN_CNT),
    .STALL_CNT (STALL_CNT)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 0; BUSYWAIT = 0; BRANCH = 0; BR_MODE = 2'd0; ZERO = 0; SIGN = 0;
    JUMP = 0; CALL = 0; RET = 0; OFFSET = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1;
    step();
    RESET = 0;
  endtask

  task automatic test_reset();
    idle();
    RESET = 1; BUSYWAIT = 1; CALL = 1;
    step();
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
    n_checks++; if (RAS_COUNT !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", RAS_COUNT); end
    n_checks++; if ({RAS_OVF, RAS_UDF} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {RAS_OVF, RAS_UDF}); end
    idle();
  endtask

  task automatic test_free_run_stall();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h4, 32'h8, 32'hC};
    do_reset();
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL free_pc0 got %h want 0", PC); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (PC !== exp_pc[i]) begin n_fail++; $display("FAIL free_pc%0d got %h want %h", i+1, PC, exp_pc[i]); end
    end
    BUSYWAIT = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (PC !== 32'hC) begin n_fail++; $display("FAIL stall_hold%0d got %h want c", i, PC); end
    end
    BUSYWAIT = 0;
    step();
    n_checks++; if (PC !== 32'h10) begin n_fail++; $display("FAIL stall_release got %h want 10", PC); end
    n_checks++; if (PC_PLUS4 !== 32'h14) begin n_fail++; $display("FAIL pc_plus4 got %h want 14", PC_PLUS4); end
  endtask

  task automatic test_branch_modes();
    do_reset();
    JUMP = 1; OFFSET = 8'h07; step(); idle();
    n_checks++; if (PC !== 32'h20) begin n_fail++; $display("FAIL jump_fwd got %h want 20", PC); end
    BRANCH = 1; BR_MODE = 2'd0; ZERO = 1; OFFSET = 8'hFE; step(); idle();
    n_checks++; if (PC !== 32'h1C) begin n_fail++; $display("FAIL beq_taken got %h want 1c", PC); end
    JUMP = 1; OFFSET = 8'h00; step(); idle();
    BRANCH = 1; BR_MODE = 2'd0; ZERO = 0; OFFSET = 8'hFE; step(); idle();
    n_checks++; if (PC !== 32'h24) begin n_fail++; $display("FAIL beq_not_taken got %h want 24", PC); end
    JUMP = 1; OFFSET = 8'hFE; step(); idle();
    n_checks++; if (PC !== 32'h20) begin n_fail++; $display("FAIL jump_back got %h want 20", PC); end
    BRANCH = 1; BR_MODE = 2'd3; SIGN = 0; OFFSET = 8'h03; step(); idle();
    n_checks++; if (PC !== 32'h30) begin n_fail++; $display("FAIL bge_taken got %h want 30", PC); end
    BRANCH = 1; BR_MODE = 2'd2; SIGN = 1; OFFSET = 8'h01; step(); idle();
    n_checks++; if (PC !== 32'h38) begin n_fail++; $display("FAIL blt_taken got %h want 38", PC); end
    BRANCH = 1; BR_MODE = 2'd1; ZERO = 1; OFFSET = 8'h10; step(); idle();
    n_checks++; if (PC !== 32'h3C) begin n_fail++; $display("FAIL bne_not_taken got %h want 3c", PC); end
    // JUMP wins over a taken branch with a different offset source is impossible; check JUMP with BRANCH not-taken
    JUMP = 1; BRANCH = 1; BR_MODE = 2'd1; ZERO = 1; OFFSET = 8'h01; step(); idle();
    n_checks++; if (PC !== 32'h44) begin n_fail++; $display("FAIL jump_over_branch got %h want 44", PC); end
    do_reset();
    JUMP = 1; OFFSET = 8'h80; step(); idle();
    n_checks++; if (PC !== 32'hFFFFFE04) begin n_fail++; $display("FAIL wrap_target got %h want fffffe04", PC); end
  endtask

  task automatic test_call_return();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    CALL = 1; OFFSET = 8'h04; step(); idle();
    n_checks++; if (PC !== 32'h24) begin n_fail++; $display("FAIL call_pc got %h want 24", PC); end
    n_checks++; if (RAS_COUNT !== 3'd1) begin n_fail++; $display("FAIL call_count got %0d want 1", RAS_COUNT); end
    RET = 1; step(); idle();
    n_checks++; if (PC !== 32'h14) begin n_fail++; $display("FAIL ret_pc got %h want 14", PC); end
    n_checks++; if (RAS_COUNT !== 3'd0) begin n_fail++; $display("FAIL ret_count got %0d want 0", RAS_COUNT); end
  endtask

  task automatic test_ovf_udf();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h14, 32'h10, 32'hC, 32'h8};
    do_reset();
    CALL = 1; OFFSET = 8'h00;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if ({RAS_COUNT, RAS_OVF} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL full_no_ovf got cnt=%0d ovf=%b want cnt=4 ovf=0", RAS_COUNT, RAS_OVF); end
    step(); idle();
    n_checks++; if ({RAS_COUNT, RAS_OVF} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL ovf got cnt=%0d ovf=%b want cnt=4 ovf=1", RAS_COUNT, RAS_OVF); end
    RET = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (PC !== exp_ret[i]) begin n_fail++; $display("FAIL pop%0d got %h want %h", i, PC, exp_ret[i]); end
    end
    n_checks++; if ({RAS_COUNT, RAS_UDF} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL empty_no_udf got cnt=%0d udf=%b want cnt=0 udf=0", RAS_COUNT, RAS_UDF); end
    step(); idle();
    n_checks++; if ({PC, RAS_UDF, RAS_OVF} !== {32'h0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL udf got pc=%h udf=%b ovf=%b want pc=0 udf=1 ovf=1", PC, RAS_UDF, RAS_OVF); end
  endtask

  task automatic test_call_ret_same();
    do_reset();
    JUMP = 1; OFFSET = 8'h3E; step(); idle();
    CALL = 1; OFFSET = 8'hD0; step(); idle();
    n_checks++; if ({PC, RAS_COUNT} !== {32'h40, 3'd1}) begin n_fail++; $display("FAIL setup got pc=%h cnt=%0d want pc=40 cnt=1", PC, RAS_COUNT); end
    CALL = 1; RET = 1; step(); idle();
    n_checks++; if ({PC, RAS_COUNT} !== {32'h100, 3'd1}) begin n_fail++; $display("FAIL callret got pc=%h cnt=%0d want pc=100 cnt=1", PC, RAS_COUNT); end
    RET = 1; step(); idle();
    n_checks++; if ({PC, RAS_COUNT, RAS_UDF} !== {32'h44, 3'd0, 1'b0}) begin n_fail++; $display("FAIL new_top got pc=%h cnt=%0d udf=%b want pc=44 cnt=0 udf=0", PC, RAS_COUNT, RAS_UDF); end
    do_reset();
    CALL = 1; RET = 1; step(); idle();
    n_checks++; if ({PC, RAS_COUNT, RAS_UDF} !== {32'h0, 3'd1, 1'b1}) begin n_fail++; $display("FAIL callret_empty got pc=%h cnt=%0d udf=%b want pc=0 cnt=1 udf=1", PC, RAS_COUNT, RAS_UDF); end
    RET = 1; step(); idle();
    n_checks++; if (PC !== 32'h4) begin n_fail++; $display("FAIL callret_empty_pop got %h want 4", PC); end
  endtask

  task automatic test_stalled_call();
    do_reset();
    CALL = 1; OFFSET = 8'h00; BUSYWAIT = 1;
    step(); step();
    n_checks++; if ({PC, RAS_COUNT} !== {32'h0, 3'd0}) begin n_fail++; $display("FAIL stall_call_hold got pc=%h cnt=%0d want pc=0 cnt=0", PC, RAS_COUNT); end
    BUSYWAIT = 0; step(); idle();
    n_checks++; if ({PC, RAS_COUNT} !== {32'h4, 3'd1}) begin n_fail++; $display("FAIL stall_call_once got pc=%h cnt=%0d want pc=4 cnt=1", PC, RAS_COUNT); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    CALL = 1; OFFSET = 8'h00; step(); step(); idle();
    JUMP = 1; OFFSET = 8'h1D; step(); idle();
    n_checks++; if ({PC, RAS_COUNT} !== {32'h80, 3'd2}) begin n_fail++; $display("FAIL pre_reset got pc=%h cnt=%0d want pc=80 cnt=2", PC, RAS_COUNT); end
    BUSYWAIT = 1; step();
    RESET = 1; step(); idle();
    n_checks++; if ({PC, RAS_COUNT, RAS_OVF, RAS_UDF} !== {32'h0, 3'd0, 2'b00}) begin n_fail++; $display("FAIL reset_in_stall got pc=%h cnt=%0d flags=%b%b want pc=0 cnt=0 flags=00", PC, RAS_COUNT, RAS_OVF, RAS_UDF); end
  endtask

  initial begin
    idle();
    test_reset();
    test_free_run_stall();
    test_branch_modes();
    test_call_return();
    test_ovf_udf();
    test_call_ret_same();
    test_stalled_call();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
